pirdsp_simd_unpack: RTL and testbench
=====================================

Name: pirdsp_simd_unpack

Overview:
- Result-side counterpart of the DSP multiply mapping.
- Multiply mapping packs narrow SIMD products into one 48-bit apirdsp/pirdsp2 P word; this block accepts those P words and unpacks them.
- Outputs each lane product as a separate 48-bit extended result over a valid/ready stream, tagged with its lane index and a last-lane flag.
- Sits between the DSP P output (or its pipeline register) and downstream accumulate/write-back logic.

Parameters:
- P_W, 48, width of the packed P word; must be divisible by 4.
- TAG_W, 4, width of the sideband tag carried from input word to every lane output.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  packed word available.
- in_ready  output  1  block can accept a word this cycle.
- in_p  input  P_W  packed DSP P word.
- in_mode  input  2  lane format: 0 = 1 lane of P_W bits; 1 = 2 lanes of P_W/2; 2 = 4 lanes of P_W/4; 3 = illegal.
- in_signed  input  1  1 = sign-extend lanes, 0 = zero-extend.
- in_tag  input  TAG_W  sideband tag.
- out_valid  output  1  lane result valid.
- out_ready  input  1  downstream accepts lane result.
- out_data  output  P_W  extended lane product.
- out_lane  output  2  lane index 0..3.
- out_last  output  1  this lane is the final lane of its word.
- out_tag  output  TAG_W  tag of the source word.
- err_mode  output  1  sticky: an illegal mode word was accepted.

Behaviour:
- Reset (async assert, sync-released flops):
  - out_valid=0, out_data=0, out_lane=0, out_last=0, out_tag=0, err_mode=0.
  - Holding register and lane counter are cleared; FSM goes to IDLE.
- Handshake:
  - Input transfer when in_valid && in_ready.
  - Output transfer when out_valid && out_ready.
  - in_ready = !out_valid || (out_ready && out_last), combinational; in_ready is 0 while rst_n=0.
  - While out_valid && !out_ready, out_data, out_lane, out_last and out_tag hold stable.
- FSM:
  - IDLE: out_valid=0. On input transfer, latch in_p, mode, signed and tag; set lane=0; go to EMIT.
  - EMIT: out_valid=1.
    - Output transfer with !out_last: lane increments.
    - Output transfer with out_last and an input transfer in the same cycle: reload from the new word, lane=0, stay in EMIT.
    - Output transfer with out_last and no input transfer: go to IDLE.
- Latency and throughput:
  - Word accepted at cycle N presents lane 0 at cycle N+1 (registered output).
  - Throughput is one lane per cycle with no bubble between words when out_ready=1.
- Lane extraction:
  - Lane width W = P_W/lanes; lane k = held_p[(k+1)W-1 : kW].
  - out_data = sign-extension of lane k when signed=1, else zero-extension, to P_W bits.
  - Mode 0 passes held_p unchanged.
- out_last = (lane == lanes-1).
- Illegal mode 3: the word is treated as mode 0 (single lane) and err_mode is set. err_mode clears only on reset.
- Reset mid-emission: remaining lanes are discarded; no output is produced after reset release until a new input transfer.
- in_p, in_mode, in_signed and in_tag are ignored when no input transfer occurs.

Test Plan:
- Reset then mode 1 signed, in_p=48'hFFF001_000010, tag=3, out_ready=1 -> cycle+1: out_data=48'h000000000010, lane 0, last 0; cycle+2: 48'hFFFFFFFFF001, lane 1, last 1, tag 3 both cycles.
- Mode 2 unsigned in_p=48'h800_7FF_123_ABC -> lanes 0..3 = 48'h...ABC, 48'h...123, 48'h...7FF, 48'h000000000800, with zero upper bits. Same word signed -> lane 3 = 48'hFFFFFFFFF800, lane 2 = 48'h0000000007FF.
- Backpressure: mode 2 word, out_ready low for 3 cycles at lane 1 -> lane 1 outputs hold stable and in_ready=0 throughout; lanes 2 and 3 follow after out_ready rises; total 4 transfers.
- Back-to-back: mode 0 words 48'h1, 48'h2, 48'h3 on consecutive cycles, out_ready=1 -> in_ready stays 1; outputs 1, 2, 3 on consecutive cycles, each with last=1.
- Illegal mode: mode 3 with in_p=48'h123456789ABC -> single output 48'h123456789ABC, last=1; err_mode=1 and stays 1 across later legal words until rst_n pulses low.
- Reset mid-word: assert rst_n=0 asynchronously during lane 1 of a mode 2 word -> out_valid drops immediately; no lanes appear after release; the next word starts at lane 0.

Source files
------------

// File: rtl/pirdsp_simd_unpack.sv
// Unpacks a packed DSP P word into 1, 2 or 4 extended lane results,
// emitted one lane per cycle over a valid/ready stream.
module pirdsp_simd_unpack #(
    parameter int P_W   = 48,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [P_W-1:0]   in_p,
    input  logic [1:0]       in_mode,
    input  logic             in_signed,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [P_W-1:0]   out_data,
    output logic [1:0]       out_lane,
    output logic             out_last,
    output logic [TAG_W-1:0] out_tag,
    output logic             err_mode
);

    localparam int H = P_W / 2;
    localparam int Q = P_W / 4;

    typedef enum logic {S_IDLE, S_EMIT} state_t;

    state_t           r_state;
    logic [P_W-1:0]   r_p;
    logic [1:0]       r_mode;
    logic             r_signed;
    logic [TAG_W-1:0] r_tag;
    logic [1:0]       r_lane;
    logic             r_out_valid;
    logic [P_W-1:0]   r_out_data;
    logic             r_out_last;
    logic             r_err;

    logic             w_in_xfer;
    logic             w_out_xfer;
    logic [1:0]       w_in_mode;
    logic [1:0]       w_lane_nxt;

    function automatic logic [P_W-1:0] f_extract(input logic [P_W-1:0] p,
                                                 input logic [1:0] mode,
                                                 input logic sgn,
                                                 input logic [1:0] lane);
        logic [P_W-1:0] res;
        logic [H-1:0]   h;
        logic [Q-1:0]   q;
        h = lane[0] ? p[P_W-1:H] : p[H-1:0];
        case (lane)
            2'd0:    q = p[Q-1:0];
            2'd1:    q = p[2*Q-1:Q];
            2'd2:    q = p[3*Q-1:2*Q];
            default: q = p[P_W-1:3*Q];
        endcase
        case (mode)
            2'd1:    res = {{H{sgn & h[H-1]}}, h};
            2'd2:    res = {{(P_W-Q){sgn & q[Q-1]}}, q};
            default: res = p;
        endcase
        return res;
    endfunction

    function automatic logic [1:0] f_last_lane(input logic [1:0] mode);
        case (mode)
            2'd1:    return 2'd1;
            2'd2:    return 2'd3;
            default: return 2'd0;
        endcase
    endfunction

    // Illegal mode 3 is folded into single-lane handling at the input.
    assign w_in_mode  = (in_mode == 2'd3) ? 2'd0 : in_mode;
    assign in_ready   = rst_n && (!r_out_valid || (out_ready && r_out_last));
    assign w_in_xfer  = in_valid && in_ready;
    assign w_out_xfer = r_out_valid && out_ready;
    assign w_lane_nxt = r_lane + 2'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_p         <= '0;
            r_mode      <= 2'd0;
            r_signed    <= 1'b0;
            r_tag       <= '0;
            r_lane      <= 2'd0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_last  <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            if (w_in_xfer && in_mode == 2'd3)
                r_err <= 1'b1;
            case (r_state)
                S_IDLE: begin
                    if (w_in_xfer) begin
                        r_state     <= S_EMIT;
                        r_p         <= in_p;
                        r_mode      <= w_in_mode;
                        r_signed    <= in_signed;
                        r_tag       <= in_tag;
                        r_lane      <= 2'd0;
                        r_out_valid <= 1'b1;
                        r_out_data  <= f_extract(in_p, w_in_mode, in_signed, 2'd0);
                        r_out_last  <= (f_last_lane(w_in_mode) == 2'd0);
                    end
                end
                S_EMIT: begin
                    // An input transfer here implies the last lane is leaving.
                    if (w_in_xfer) begin
                        r_p         <= in_p;
                        r_mode      <= w_in_mode;
                        r_signed    <= in_signed;
                        r_tag       <= in_tag;
                        r_lane      <= 2'd0;
                        r_out_data  <= f_extract(in_p, w_in_mode, in_signed, 2'd0);
                        r_out_last  <= (f_last_lane(w_in_mode) == 2'd0);
                    end else if (w_out_xfer) begin
                        if (!r_out_last) begin
                            r_lane     <= w_lane_nxt;
                            r_out_data <= f_extract(r_p, r_mode, r_signed, w_lane_nxt);
                            r_out_last <= (f_last_lane(r_mode) == w_lane_nxt);
                        end else begin
                            r_state     <= S_IDLE;
                            r_out_valid <= 1'b0;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_lane  = r_lane;
    assign out_last  = r_out_last;
    assign out_tag   = r_tag;
    assign err_mode  = r_err;

endmodule

// File: tb/tb_pirdsp_simd_unpack.sv
// Directed self-checking bench for pirdsp_simd_unpack.
module tb_pirdsp_simd_unpack;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [47:0] in_p;
    logic [1:0]  in_mode;
    logic        in_signed;
    logic [3:0]  in_tag;
    logic        out_valid;
    logic        out_ready;
    logic [47:0] out_data;
    logic [1:0]  out_lane;
    logic        out_last;
    logic [3:0]  out_tag;
    logic        err_mode;

    int n_vec = 0;
    int n_err = 0;
    int n_xfer = 0;
    int xfer_base;

    pirdsp_simd_unpack #(.P_W(48), .TAG_W(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_p(in_p),
        .in_mode(in_mode), .in_signed(in_signed), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_lane(out_lane), .out_last(out_last), .out_tag(out_tag),
        .err_mode(err_mode)
    );

    always #5 clk = ~clk;

    always @(posedge clk)
        if (out_valid && out_ready) n_xfer++;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_lane(input string name, input logic [47:0] d, input logic [1:0] ln,
                            input logic last, input logic [3:0] tg);
        chk({name, ".valid"}, {63'd0, out_valid}, 64'd1);
        chk({name, ".data"},  {16'd0, out_data},  {16'd0, d});
        chk({name, ".lane"},  {62'd0, out_lane},  {62'd0, ln});
        chk({name, ".last"},  {63'd0, out_last},  {63'd0, last});
        chk({name, ".tag"},   {60'd0, out_tag},   {60'd0, tg});
    endtask

    // Present a word, confirm it will be taken, clock it in.
    task automatic send(input logic [47:0] p, input logic [1:0] m, input logic s, input logic [3:0] t);
        in_valid = 1'b1; in_p = p; in_mode = m; in_signed = s; in_tag = t;
        #1;
        chk("send.in_ready", {63'd0, in_ready}, 64'd1);
        tick();
        in_valid = 1'b0;
    endtask

    logic [47:0] exp_u [4];
    logic [47:0] exp_s [4];

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_p = '0; in_mode = 2'd0;
        in_signed = 1'b0; in_tag = '0; out_ready = 1'b1;
        #12;
        chk("rst.in_ready",  {63'd0, in_ready},  64'd0);
        chk("rst.out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst.out_data",  {16'd0, out_data},  64'd0);
        chk("rst.out_lane",  {62'd0, out_lane},  64'd0);
        chk("rst.out_last",  {63'd0, out_last},  64'd0);
        chk("rst.out_tag",   {60'd0, out_tag},   64'd0);
        chk("rst.err_mode",  {63'd0, err_mode},  64'd0);
        @(negedge clk); rst_n = 1'b1;
        tick();

        // Mode 1 signed
        send(48'hFFF001_000010, 2'd1, 1'b1, 4'd3);
        chk_lane("m1.l0", 48'h000000000010, 2'd0, 1'b0, 4'd3);
        tick();
        chk_lane("m1.l1", 48'hFFFFFFFFF001, 2'd1, 1'b1, 4'd3);
        tick();
        chk("m1.idle", {63'd0, out_valid}, 64'd0);

        // Mode 2 unsigned then signed
        exp_u[0] = 48'h000000000ABC; exp_u[1] = 48'h000000000123;
        exp_u[2] = 48'h0000000007FF; exp_u[3] = 48'h000000000800;
        exp_s[0] = 48'hFFFFFFFFFABC; exp_s[1] = 48'h000000000123;
        exp_s[2] = 48'h0000000007FF; exp_s[3] = 48'hFFFFFFFFF800;
        send(48'h800_7FF_123_ABC, 2'd2, 1'b0, 4'd5);
        for (int k = 0; k < 4; k++) begin
            chk_lane("m2u", exp_u[k], 2'(k), k == 3, 4'd5);
            tick();
        end
        chk("m2u.idle", {63'd0, out_valid}, 64'd0);
        send(48'h800_7FF_123_ABC, 2'd2, 1'b1, 4'd6);
        for (int k = 0; k < 4; k++) begin
            chk_lane("m2s", exp_s[k], 2'(k), k == 3, 4'd6);
            tick();
        end

        // Backpressure at lane 1
        xfer_base = n_xfer;
        send(48'hDDD_CCC_BBB_AAA, 2'd2, 1'b0, 4'd9);
        chk_lane("bp.l0", 48'h000000000AAA, 2'd0, 1'b0, 4'd9);
        tick();
        out_ready = 1'b0;
        in_valid = 1'b1; in_p = 48'h111111111111; in_mode = 2'd0; in_tag = 4'd1;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk("bp.in_ready", {63'd0, in_ready}, 64'd0);
            chk_lane("bp.hold", 48'h000000000BBB, 2'd1, 1'b0, 4'd9);
            tick();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        chk_lane("bp.l1", 48'h000000000BBB, 2'd1, 1'b0, 4'd9);
        tick();
        chk_lane("bp.l2", 48'h000000000CCC, 2'd2, 1'b0, 4'd9);
        tick();
        chk_lane("bp.l3", 48'h000000000DDD, 2'd3, 1'b1, 4'd9);
        tick();
        chk("bp.xfers", 64'(n_xfer - xfer_base), 64'd4);

        // Back-to-back mode 0 words
        send(48'h1, 2'd0, 1'b0, 4'd1);
        for (int k = 2; k <= 3; k++) begin
            chk_lane("b2b", 48'(k - 1), 2'd0, 1'b1, 4'(k - 1));
            send(48'(k), 2'd0, 1'b0, 4'(k));
        end
        chk_lane("b2b.3", 48'h3, 2'd0, 1'b1, 4'd3);
        tick();
        chk("b2b.idle", {63'd0, out_valid}, 64'd0);

        // Illegal mode 3 and sticky error
        send(48'h123456789ABC, 2'd3, 1'b1, 4'd7);
        chk_lane("ill", 48'h123456789ABC, 2'd0, 1'b1, 4'd7);
        chk("ill.err", {63'd0, err_mode}, 64'd1);
        tick();
        chk("ill.idle", {63'd0, out_valid}, 64'd0);
        send(48'h000005_000004, 2'd1, 1'b0, 4'd2);
        chk_lane("ill.next", 48'h000000000004, 2'd0, 1'b0, 4'd2);
        tick();
        tick();
        chk("ill.err_sticky", {63'd0, err_mode}, 64'd1);
        rst_n = 1'b0;
        #2;
        chk("ill.err_clr", {63'd0, err_mode}, 64'd0);
        @(negedge clk); rst_n = 1'b1;
        tick();

        // Reset during lane 1
        send(48'h444_333_222_111, 2'd2, 1'b0, 4'd4);
        tick();
        chk_lane("rmid.l1", 48'h000000000222, 2'd1, 1'b0, 4'd4);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rmid.valid_drop", {63'd0, out_valid}, 64'd0);
        chk("rmid.in_ready",   {63'd0, in_ready},  64'd0);
        @(negedge clk); rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("rmid.quiet", {63'd0, out_valid}, 64'd0);
        end
        send(48'h888_777_666_555, 2'd2, 1'b0, 4'd8);
        chk_lane("rmid.new", 48'h000000000555, 2'd0, 1'b0, 4'd8);
        tick();
        chk_lane("rmid.new1", 48'h000000000666, 2'd1, 1'b0, 4'd8);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
